// File: rtl/ws2812_rx.sv
// WS2812/NeoPixel stream decoder: classifies high pulses by width into bits,
// assembles 24-bit pixel words and detects the low latch gap as end of frame.
module ws2812_rx #(
  parameter int NUM_LEDS     = 8,
  parameter int SYSTEM_CLOCK = 50000000,
  parameter int T_THRESH_NS  = 625,
  parameter int T_MIN_NS     = 150,
  parameter int T_MAX_NS     = 1500,
  parameter int T_RESET_NS   = 50000,
  localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1,
  localparam int CW = $clog2(NUM_LEDS) + 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          di_i,
  output logic [23:0]   data_o,
  output logic [AW-1:0] addr_o,
  output logic          valid_o,
  output logic          frame_done_o,
  output logic [CW-1:0] led_count_o,
  output logic          overflow_o,
  output logic          err_o,
  output logic [1:0]    err_code_o,
  output logic          busy_o
);

  localparam int MHZ        = SYSTEM_CLOCK / 1000000;
  localparam int THRESH_CYC = MHZ * T_THRESH_NS / 1000;
  localparam int MIN_CYC    = MHZ * T_MIN_NS / 1000;
  localparam int MAX_CYC    = MHZ * T_MAX_NS / 1000;
  localparam int RESET_CYC  = MHZ * T_RESET_NS / 1000;
  localparam int TW         = $clog2(RESET_CYC + 1);

  localparam logic [TW-1:0] CNT_SAT    = TW'(RESET_CYC);
  localparam logic [TW:0]   THRESH_LIM = (TW + 1)'(THRESH_CYC);
  localparam logic [TW:0]   MIN_LIM    = (TW + 1)'(MIN_CYC);
  localparam logic [TW:0]   MAX_LIM    = (TW + 1)'(MAX_CYC);
  localparam logic [TW:0]   RESET_LIM  = (TW + 1)'(RESET_CYC);
  localparam logic [CW-1:0] NUM_LIM    = CW'(NUM_LEDS);

  // SYNC: wait for a quiet line | IDLE: armed for a frame | HIGH: timing a pulse | LOW: timing a gap
  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  state_t        state, state_nxt;
  logic          di_meta, di_s, di_q;
  logic          rise, fall;
  logic [TW-1:0] cnt;
  logic [TW:0]   elapsed;
  logic          cnt_clr;
  logic [22:0]   shift;
  logic [4:0]    bit_cnt;
  logic [CW-1:0] word_cnt;
  logic          ovf_flag;

  logic          take_bit;
  logic          bit_val;
  logic          frame_start;
  logic          frame_end;
  logic          err_set;
  logic [1:0]    err_val;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      di_meta <= 1'b0;
      di_s    <= 1'b0;
      di_q    <= 1'b0;
    end else begin
      di_meta <= di_i;
      di_s    <= di_meta;
      di_q    <= di_s;
    end
  end

  assign rise = di_s & ~di_q;
  assign fall = ~di_s & di_q;

  // elapsed counts the cycles since the last detected edge, including the current one
  assign elapsed = {1'b0, cnt} + {{TW{1'b0}}, 1'b1};
  assign cnt_clr = (state == SYNC) ? di_s : (rise | fall);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (cnt != CNT_SAT) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= SYNC;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    take_bit    = 1'b0;
    bit_val     = (elapsed >= THRESH_LIM);
    frame_start = 1'b0;
    frame_end   = 1'b0;
    err_set     = 1'b0;
    err_val     = 2'd0;
    case (state)
      SYNC: begin
        if (!di_s && (elapsed >= RESET_LIM)) begin
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        if (rise) begin
          state_nxt   = HIGH;
          frame_start = 1'b1;
        end
      end
      HIGH: begin
        // a pulse that reaches the maximum is stuck even if it falls in the same cycle
        if (elapsed >= MAX_LIM) begin
          err_set   = 1'b1;
          err_val   = 2'd2;
          state_nxt = SYNC;
        end else if (fall) begin
          if (elapsed < MIN_LIM) begin
            err_set   = 1'b1;
            err_val   = 2'd1;
            state_nxt = SYNC;
          end else begin
            take_bit  = 1'b1;
            state_nxt = LOW;
          end
        end
      end
      LOW: begin
        if (rise) begin
          state_nxt = HIGH;
        end else if (elapsed >= RESET_LIM) begin
          frame_end = 1'b1;
          state_nxt = IDLE;
          if (bit_cnt != 5'd0) begin
            err_set = 1'b1;
            err_val = 2'd3;
          end
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      shift        <= '0;
      bit_cnt      <= '0;
      word_cnt     <= '0;
      ovf_flag     <= 1'b0;
      data_o       <= '0;
      addr_o       <= '0;
      valid_o      <= 1'b0;
      frame_done_o <= 1'b0;
      led_count_o  <= '0;
      overflow_o   <= 1'b0;
      err_o        <= 1'b0;
      err_code_o   <= 2'd0;
    end else begin
      valid_o      <= 1'b0;
      frame_done_o <= 1'b0;
      err_o        <= 1'b0;
      if (frame_start) begin
        shift    <= '0;
        bit_cnt  <= '0;
        word_cnt <= '0;
        ovf_flag <= 1'b0;
      end
      if (take_bit) begin
        shift <= {shift[21:0], bit_val};
        if (bit_cnt == 5'd23) begin
          bit_cnt <= '0;
          if (word_cnt < NUM_LIM) begin
            data_o   <= {shift, bit_val};
            addr_o   <= word_cnt[AW-1:0];
            valid_o  <= 1'b1;
            word_cnt <= word_cnt + 1'b1;
          end else begin
            ovf_flag <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      if (frame_end) begin
        frame_done_o <= 1'b1;
        led_count_o  <= word_cnt;
        overflow_o   <= ovf_flag;
      end
      if (err_set) begin
        err_o      <= 1'b1;
        err_code_o <= err_val;
      end
    end
  end

  assign busy_o = (state == HIGH) || (state == LOW);

endmodule

// File: tb/tb_ws2812_rx.sv
// Randomized scoreboard bench for ws2812_rx: frames are described as pulse-width lists,
// a width-rule model predicts words, frame ends and errors, and a monitor checks them.
module tb_ws2812_rx;
  localparam int NUM_LEDS = 8;
  localparam int TH_W  = 31;
  localparam int MIN_W = 7;
  localparam int MAX_W = 75;

  logic        clk;
  logic        reset;
  logic        di;
  logic [23:0] data_o;
  logic [2:0]  addr_o;
  logic        valid_o;
  logic        frame_done_o;
  logic [3:0]  led_count_o;
  logic        overflow_o;
  logic        err_o;
  logic [1:0]  err_code_o;
  logic        busy_o;

  ws2812_rx #(.NUM_LEDS(NUM_LEDS)) dut (
    .clk_i(clk), .reset_i(reset), .di_i(di),
    .data_o(data_o), .addr_o(addr_o), .valid_o(valid_o),
    .frame_done_o(frame_done_o), .led_count_o(led_count_o), .overflow_o(overflow_o),
    .err_o(err_o), .err_code_o(err_code_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct packed {logic [23:0] data; logic [2:0] addr;} vexp_t;
  typedef struct packed {logic [3:0] cnt; logic ovf; logic partial;} fexp_t;

  vexp_t      exp_v[$];
  fexp_t      exp_f[$];
  logic [1:0] exp_e[$];
  int         highs[$];
  int         lows[$];
  int         n_chk = 0;
  int         n_pass = 0;
  bit         armed;
  logic [3:0] last_cnt;
  logic       last_ovf;
  logic [1:0] last_code;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Reference: pulse widths -> bits by threshold, 24 bits per word, errors by width limits.
  task automatic model_frame(input int gap);
    int words, bits, cnt;
    logic [23:0] sh;
    bit bad;
    vexp_t ev;
    fexp_t ef;
    words = 0; bits = 0; sh = '0; bad = 0;
    if (armed) begin
      for (int i = 0; i < highs.size(); i++) begin
        if (highs[i] >= MAX_W) begin
          exp_e.push_back(2'd2); last_code = 2'd2; bad = 1; break;
        end
        if (highs[i] < MIN_W) begin
          exp_e.push_back(2'd1); last_code = 2'd1; bad = 1; break;
        end
        sh = {sh[22:0], 1'(highs[i] >= TH_W)};
        bits++;
        if (bits == 24) begin
          if (words < NUM_LEDS) begin
            ev.data = sh; ev.addr = 3'(words);
            exp_v.push_back(ev);
          end
          words++;
          bits = 0;
        end
      end
      if (!bad) begin
        cnt = (words < NUM_LEDS) ? words : NUM_LEDS;
        ef.cnt = 4'(cnt); ef.ovf = (words > NUM_LEDS); ef.partial = (bits != 0);
        exp_f.push_back(ef);
        last_cnt = ef.cnt; last_ovf = ef.ovf;
        if (bits != 0) last_code = 2'd3;
      end
    end
    armed = (gap >= 2600);
  endtask

  task automatic drive(input int gap);
    for (int i = 0; i < highs.size(); i++) begin
      di = 1'b1;
      repeat (highs[i]) @(negedge clk);
      di = 1'b0;
      repeat ((i == highs.size() - 1) ? gap : lows[i]) @(negedge clk);
    end
    highs.delete();
    lows.delete();
  endtask

  task automatic send(input int gap);
    model_frame(gap);
    drive(gap);
  endtask

  task automatic add_pulse(input int h, input int l);
    highs.push_back(h);
    lows.push_back(l);
  endtask

  task automatic add_bits(input logic [23:0] w, input int n, input bit fixed_w);
    logic v;
    for (int k = 0; k < n; k++) begin
      v = w[23 - k];
      if (fixed_w) add_pulse(v ? 40 : 20, v ? 22 : 43);
      else add_pulse(v ? int'($urandom_range(31, 60)) : int'($urandom_range(7, 30)),
                     int'($urandom_range(3, 15)));
    end
  endtask

  vexp_t      mv;
  fexp_t      mf;
  logic [1:0] me;

  always @(negedge clk) begin
    if (!reset) begin
      if (valid_o) begin
        if (exp_v.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_valid: got data 0x%06h addr %0d, required no word", data_o, addr_o);
        end else begin
          mv = exp_v.pop_front();
          chk("valid_data", 32'(data_o), 32'(mv.data));
          chk("valid_addr", 32'(addr_o), 32'(mv.addr));
          chk("busy_at_valid", 32'(busy_o), 32'd1);
        end
      end
      if (frame_done_o) begin
        if (exp_f.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_frame_done: got led_count %0d, required no frame end", led_count_o);
        end else begin
          mf = exp_f.pop_front();
          chk("led_count", 32'(led_count_o), 32'(mf.cnt));
          chk("overflow", 32'(overflow_o), 32'(mf.ovf));
          chk("partial_err", 32'(err_o && (err_code_o == 2'd3)), 32'(mf.partial));
        end
      end
      if (err_o && !frame_done_o) begin
        if (exp_e.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_err: got code %0d, required no error", err_code_o);
        end else begin
          me = exp_e.pop_front();
          chk("err_code", 32'(err_code_o), 32'(me));
          chk("busy_after_err", 32'(busy_o), 32'd0);
        end
      end
    end
  end

  logic [23:0] w;
  int nw, nb, idx, sel;

  initial begin
    reset = 1'b1; di = 1'b0; armed = 0;
    last_cnt = '0; last_ovf = 1'b0; last_code = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);
    chk("rst_frame_done", 32'(frame_done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    reset = 1'b0;
    repeat (2600) @(negedge clk);
    armed = 1;

    // single pixel with the nominal widths
    add_bits(24'hFF0055, 24, 1);
    send(3000);

    // ten words into an eight-word receiver
    for (int p = 1; p <= 10; p++) add_bits(24'(p), 24, 0);
    send(2600);

    // threshold and width-limit boundaries
    add_pulse(30, 10); add_pulse(31, 10); add_pulse(7, 10); add_pulse(74, 10);
    add_bits(24'($urandom), 20, 0);
    send(2600);
    add_pulse(20, 40); add_pulse(40, 20); add_pulse(6, 20); add_bits(24'hA50000, 8, 0);
    send(3000);
    chk("err_code_held", 32'(err_code_o), 32'(last_code));
    chk("led_count_held_glitch", 32'(led_count_o), 32'(last_cnt));
    add_bits(24'($urandom), 24, 0);
    send(3000);

    // stuck-high mid-frame, then a too-early frame, then a clean one
    add_bits(24'($urandom), 24, 0);
    add_bits(24'($urandom), 5, 0);
    add_pulse(100, 30);
    add_bits(24'($urandom), 10, 0);
    send(1000);
    chk("busy_in_sync", 32'(busy_o), 32'd0);
    chk("led_count_held_stuck", 32'(led_count_o), 32'(last_cnt));
    chk("overflow_held_stuck", 32'(overflow_o), 32'(last_ovf));
    add_bits(24'($urandom), 24, 0);
    send(2600);
    add_bits(24'($urandom), 24, 0);
    send(2600);

    // partial word at frame end
    add_bits(24'($urandom), 12, 0);
    send(3000);

    // reset in the middle of bit 10 of the second pixel
    w = 24'($urandom);
    add_bits(w, 24, 0);
    mv.data = w; mv.addr = 3'd0;
    exp_v.push_back(mv);
    add_bits(24'($urandom), 9, 0);
    drive(10);
    di = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_data", 32'(data_o), 32'd0);
    chk("mid_rst_addr", 32'(addr_o), 32'd0);
    chk("mid_rst_led_count", 32'(led_count_o), 32'd0);
    chk("mid_rst_overflow", 32'(overflow_o), 32'd0);
    chk("mid_rst_err_code", 32'(err_code_o), 32'd0);
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    reset = 1'b0; di = 1'b0;
    armed = 0; last_cnt = '0; last_ovf = 1'b0; last_code = 2'd0;
    repeat (200) @(negedge clk);
    add_bits(24'($urandom), 24, 0);
    send(2600);
    add_bits(24'($urandom), 24, 0);
    send(2600);

    // randomized frames with occasional glitch or stuck pulses
    for (int f = 0; f < 8; f++) begin
      nw = $urandom_range(0, 2);
      nb = $urandom_range(0, 23);
      if (nw == 0 && nb == 0) nb = 1;
      for (int k = 0; k < nw; k++) add_bits(24'($urandom), 24, 0);
      if (nb > 0) add_bits(24'($urandom), nb, 0);
      sel = $urandom_range(0, 5);
      idx = $urandom_range(0, highs.size() - 1);
      if (sel == 0) highs[idx] = $urandom_range(1, 6);
      else if (sel == 1) highs[idx] = $urandom_range(75, 110);
      send(2600);
    end

    repeat (50) @(negedge clk);
    chk("leftover_expectations", 32'(exp_v.size() + exp_f.size() + exp_e.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
